// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported instruction/data memory between fetch (IF) and data (MEM) accesses.
// Data accesses take priority over fetch. Each grant runs one req/ack transaction with an optional timeout abort.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no transaction outstanding; grant is decided at this cycle's end
// S_DATA  | data load/store outstanding on the memory port
// S_FETCH | instruction fetch outstanding on the memory port
module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [2:0]  dm_funct3,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT > 0);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_FETCH} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [2:0]    r_mem_funct3;
    logic          r_dm_done;
    logic [31:0]   r_dm_rdata;
    logic          r_if_valid;
    logic [31:0]   r_if_rdata;
    logic          r_bus_err;

    logic w_data_elig;
    logic w_fetch_elig;
    logic w_timeout;

    // The registered done/valid pulses mask the request that just completed.
    assign w_data_elig  = (dm_read | dm_write) & ~r_dm_done;
    assign w_fetch_elig = if_req & ~r_if_valid;
    assign w_timeout    = TO_EN && (r_cnt == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_funct3 <= '0;
            r_dm_done    <= 1'b0;
            r_dm_rdata   <= '0;
            r_if_valid   <= 1'b0;
            r_if_rdata   <= '0;
            r_bus_err    <= 1'b0;
        end else begin
            r_dm_done  <= 1'b0;
            r_if_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_data_elig) begin
                        r_state      <= S_DATA;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= dm_write;
                        r_mem_addr   <= dm_addr;
                        r_mem_wdata  <= dm_wdata;
                        r_mem_funct3 <= dm_funct3;
                    end else if (w_fetch_elig) begin
                        r_state      <= S_FETCH;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= if_addr;
                        r_mem_wdata  <= '0;
                        r_mem_funct3 <= 3'b010;
                    end
                end
                S_DATA, S_FETCH: begin
                    if (mem_ack || w_timeout) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                        r_cnt     <= '0;
                        if (!mem_ack) begin
                            r_bus_err <= 1'b1;
                        end
                        if (r_state == S_DATA) begin
                            r_dm_done  <= 1'b1;
                            r_dm_rdata <= (mem_ack && !r_mem_we) ? mem_rdata : 32'h0;
                        end else begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= mem_ack ? mem_rdata : 32'h0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_funct3 = r_mem_funct3;
    assign dm_done    = r_dm_done;
    assign dm_rdata   = r_dm_rdata;
    assign if_valid   = r_if_valid;
    assign if_rdata   = r_if_rdata;
    assign bus_err    = r_bus_err;

    assign stall_mem = (dm_read | dm_write) & ~r_dm_done;
    assign stall_if  = stall_mem | (if_req & ~r_if_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed cycle-exact expectations.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_funct3;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata;
    logic        bus_err;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_funct3(dm_funct3), .dm_rdata(dm_rdata), .dm_done(dm_done),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks on the (ack_delay+1)-th cycle of mem_req.
    int          ack_delay = 0;
    bit          ack_off = 1'b0;
    bit          force_ack = 1'b0;
    int          r_wait = 0;
    logic [31:0] resp_rdata = 32'h0;
    assign mem_rdata = resp_rdata;

    always @(posedge clk) begin
        #1;
        if (force_ack) begin
            mem_ack = 1'b1;
        end else if (mem_req && !ack_off) begin
            mem_ack = (r_wait == ack_delay);
            r_wait++;
        end else begin
            mem_ack = 1'b0;
            r_wait = 0;
        end
    end

    // Reference model: one outstanding transaction record plus done/valid/error flags.
    logic        x_open, x_is_data, x_we;
    logic [31:0] x_addr, x_wdata, x_dm_rdata, x_if_rdata;
    logic [2:0]  x_f3;
    int          x_age;
    logic        x_dm_done, x_if_valid, x_bus_err;
    logic        d_el, f_el;

    task model_finish(input logic [31:0] d);
        x_open = 1'b0;
        if (x_is_data) begin
            x_dm_done = 1'b1;
            x_dm_rdata = x_we ? 32'h0 : d;
        end else begin
            x_if_valid = 1'b1;
            x_if_rdata = d;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            x_open = 0; x_is_data = 0; x_we = 0; x_addr = 0; x_wdata = 0; x_f3 = 0; x_age = 0;
            x_dm_done = 0; x_if_valid = 0; x_bus_err = 0; x_dm_rdata = 0; x_if_rdata = 0;
        end else begin
            d_el = (dm_read | dm_write) & ~x_dm_done;
            f_el = if_req & ~x_if_valid;
            x_dm_done = 1'b0;
            x_if_valid = 1'b0;
            if (!x_open) begin
                if (d_el) begin
                    x_open = 1; x_is_data = 1; x_addr = dm_addr; x_we = dm_write;
                    x_wdata = dm_wdata; x_f3 = dm_funct3; x_age = 0;
                end else if (f_el) begin
                    x_open = 1; x_is_data = 0; x_addr = if_addr; x_we = 0;
                    x_wdata = 0; x_f3 = 3'b010; x_age = 0;
                end
            end else if (mem_ack) begin
                model_finish(mem_rdata);
            end else begin
                x_age++;
                if (TO != 0 && x_age == TO) begin
                    model_finish(32'h0);
                    x_bus_err = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("mdl_mem_req", 32'(mem_req), 32'(x_open));
        if (x_open) begin
            chk("mdl_mem_addr", mem_addr, x_addr);
            chk("mdl_mem_we", 32'(mem_we), 32'(x_we));
            chk("mdl_mem_funct3", 32'(mem_funct3), 32'(x_f3));
            if (x_is_data) chk("mdl_mem_wdata", mem_wdata, x_wdata);
        end
        chk("mdl_dm_done", 32'(dm_done), 32'(x_dm_done));
        chk("mdl_if_valid", 32'(if_valid), 32'(x_if_valid));
        chk("mdl_bus_err", 32'(bus_err), 32'(x_bus_err));
        chk("mdl_stall_mem", 32'(stall_mem), 32'((dm_read | dm_write) & ~x_dm_done));
        chk("mdl_stall_if", 32'(stall_if),
            32'(((dm_read | dm_write) & ~x_dm_done) | (if_req & ~x_if_valid)));
        if (x_dm_done) chk("mdl_dm_rdata", dm_rdata, x_dm_rdata);
        if (x_if_valid) chk("mdl_if_rdata", if_rdata, x_if_rdata);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int cnt;
    bit seen;

    initial begin
        reset = 1; if_req = 0; if_addr = 0; dm_read = 0; dm_write = 0;
        dm_addr = 0; dm_wdata = 0; dm_funct3 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_stall_if", 32'(stall_if), 0);
        tick(); reset = 0;
        tick();

        // Single fetch, ack on first mem_req cycle
        ack_delay = 0; ack_off = 0; resp_rdata = 32'h00500093;
        tick(); if_req = 1; if_addr = 32'h40;
        @(negedge clk);
        chk("t1_c0_stall_if", 32'(stall_if), 1);
        chk("t1_c0_mem_req", 32'(mem_req), 0);
        tick(); @(negedge clk);
        chk("t1_c1_mem_req", 32'(mem_req), 1);
        chk("t1_c1_mem_addr", mem_addr, 32'h40);
        chk("t1_c1_stall_if", 32'(stall_if), 1);
        tick(); @(negedge clk);
        chk("t1_c2_if_valid", 32'(if_valid), 1);
        chk("t1_c2_if_rdata", if_rdata, 32'h00500093);
        chk("t1_c2_stall_if", 32'(stall_if), 0);
        tick(); if_req = 0;

        // Simultaneous lw and fetch, ack after 2 wait cycles
        ack_delay = 2; resp_rdata = 32'h12345678;
        tick(); dm_read = 1; dm_addr = 32'h100; if_req = 1; if_addr = 32'h80;
        tick(); @(negedge clk);
        chk("t2_c1_mem_req", 32'(mem_req), 1);
        chk("t2_c1_mem_addr", mem_addr, 32'h100);
        chk("t2_c1_mem_we", 32'(mem_we), 0);
        tick(); tick(); tick(); @(negedge clk);
        chk("t2_c4_dm_done", 32'(dm_done), 1);
        chk("t2_c4_dm_rdata", dm_rdata, 32'h12345678);
        chk("t2_c4_stall_mem", 32'(stall_mem), 0);
        tick(); dm_read = 0; resp_rdata = 32'h00A00113;
        @(negedge clk);
        chk("t2_c5_mem_req", 32'(mem_req), 1);
        chk("t2_c5_mem_addr", mem_addr, 32'h80);
        chk("t2_c5_funct3", 32'(mem_funct3), 32'h2);
        cnt = 0;
        while (!if_valid && cnt < 20) begin
            tick(); @(negedge clk); cnt++;
        end
        chk("t2_fetch_cycles", cnt, 3);
        chk("t2_if_rdata", if_rdata, 32'h00A00113);
        tick(); if_req = 0;

        // sw with input change after grant
        ack_delay = 1; resp_rdata = 32'hCAFEF00D;
        tick(); dm_write = 1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF; dm_funct3 = 3'b010;
        tick(); @(negedge clk);
        chk("t3_c1_mem_we", 32'(mem_we), 1);
        chk("t3_c1_mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick(); dm_addr = 32'h999; dm_wdata = 32'h0;
        @(negedge clk);
        chk("t3_c2_mem_addr", mem_addr, 32'h200);
        chk("t3_c2_mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick(); @(negedge clk);
        chk("t3_c3_dm_done", 32'(dm_done), 1);
        chk("t3_c3_dm_rdata", dm_rdata, 0);
        chk("t3_c3_stall_mem", 32'(stall_mem), 0);
        tick(); dm_write = 0;

        // lw with address/size change while waiting
        ack_delay = 3;
        tick(); dm_read = 1; dm_addr = 32'h300; dm_funct3 = 3'b100;
        tick();
        tick(); dm_addr = 32'h3FC;
        @(negedge clk);
        chk("t4_c2_mem_addr", mem_addr, 32'h300);
        tick(); dm_funct3 = 3'b000;
        @(negedge clk);
        chk("t4_c3_mem_addr", mem_addr, 32'h300);
        chk("t4_c3_funct3", 32'(mem_funct3), 32'h4);
        tick(); tick(); @(negedge clk);
        chk("t4_c5_dm_done", 32'(dm_done), 1);
        chk("t4_c5_dm_rdata", dm_rdata, 32'hCAFEF00D);
        tick(); dm_read = 0;

        // Timeout with memory never acking
        ack_off = 1;
        tick(); dm_read = 1; dm_addr = 32'h400;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick(); @(negedge clk);
            if (mem_req) cnt++;
            else break;
        end
        chk("t5_req_cycles", cnt, TO);
        chk("t5_dm_done", 32'(dm_done), 1);
        chk("t5_dm_rdata", dm_rdata, 0);
        chk("t5_bus_err", 32'(bus_err), 1);
        tick(); dm_read = 0; ack_off = 0; ack_delay = 0; resp_rdata = 32'h00000013;
        tick(); if_req = 1; if_addr = 32'h44;
        tick(); tick(); @(negedge clk);
        chk("t5_after_if_valid", 32'(if_valid), 1);
        chk("t5_sticky_bus_err", 32'(bus_err), 1);
        tick(); if_req = 0;

        // Reset mid-fetch, late ack afterwards
        ack_off = 1;
        tick(); if_req = 1; if_addr = 32'h500;
        tick(); @(negedge clk);
        chk("t6_c1_mem_req", 32'(mem_req), 1);
        tick(); #2 reset = 1; if_req = 0;
        #1;
        chk("t6_rst_mem_req", 32'(mem_req), 0);
        chk("t6_rst_mem_addr", mem_addr, 0);
        chk("t6_rst_mem_funct3", 32'(mem_funct3), 0);
        chk("t6_rst_bus_err", 32'(bus_err), 0);
        chk("t6_rst_if_rdata", if_rdata, 0);
        chk("t6_rst_dm_rdata", dm_rdata, 0);
        tick(); tick(); reset = 0;
        @(negedge clk); force_ack = 1;
        @(negedge clk); force_ack = 0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (if_valid || mem_req) seen = 1;
        end
        chk("t6_late_ack_ignored", 32'(seen), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported instruction/data memory between the IF stage and the MEM stage of the 5-stage RISC-V pipeline. A fixed-priority FSM grants data accesses (lw/sw, driven by the decoded MemRead/MemWrite controls) ahead of instruction fetch. It runs a req/ack handshake with a variable-latency memory, returns read data, and generates the stall signals the pipeline uses to freeze while an access is outstanding.

## Interface
- TIMEOUT, 16, max cycles mem_req waits for mem_ack before abort; 0 disables timeout
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  IF stage requests an instruction word; held until if_valid
- if_addr  in  32  fetch address (PC), stable while if_req
- if_rdata  out  32  fetched instruction, valid while if_valid
- if_valid  out  1  one-cycle pulse: fetch complete
- dm_read  in  1  MemRead from EX/MEM register
- dm_write  in  1  MemWrite from EX/MEM register
- dm_addr  in  32  data address (ALU result)
- dm_wdata  in  32  store data
- dm_funct3  in  3  access size/sign, passed through to memory
- dm_rdata  out  32  load data, valid while dm_done
- dm_done  out  1  one-cycle pulse: data access complete
- stall_if  out  1  freeze PC and IF/ID
- stall_mem  out  1  freeze the whole pipeline up to MEM/WB
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_funct3  out  3  access size to memory
- mem_ack  in  1  memory completes the request this cycle
- mem_rdata  in  32  read data, valid with mem_ack
- bus_err  out  1  sticky: a timeout occurred; cleared only by reset

## Operation
- States: IDLE, DATA, FETCH.
- Eligibility:
  - The data request is eligible when (dm_read | dm_write) & ~dm_done.
  - The fetch request is eligible when if_req & ~if_valid.
  - This masks the completed request in its done cycle, before the pipeline advances.
- IDLE:
  - Eligible data request → DATA.
  - Otherwise eligible fetch request → FETCH.
  - Data always wins a simultaneous request.
- On grant, register the following and set mem_req=1:
  - mem_addr, mem_we (= dm_write for data, 0 for fetch)
  - mem_wdata, mem_funct3 (3'b010 for fetch)
- The request is latched at grant. Later changes on the dm_*/if_* inputs are ignored until completion.
- DATA/FETCH:
  - Hold all mem_* outputs constant.
  - On mem_ack: clear mem_req and return to IDLE.
  - On mem_ack in DATA: pulse dm_done, and register dm_rdata=mem_rdata for reads (0 for writes).
  - On mem_ack in FETCH: pulse if_valid and register if_rdata=mem_rdata.
- Timeout:
  - A wait counter (width $clog2(TIMEOUT+1)) clears at grant and increments each busy cycle without ack.
  - When it reaches TIMEOUT: drop mem_req, return to IDLE, pulse the matching done/valid with rdata=0, and set bus_err.
- mem_ack is ignored in IDLE.
- stall_mem = (dm_read|dm_write) & ~dm_done, combinational.
- stall_if = stall_mem | (if_req & ~if_valid), combinational.
- Reset, including mid-transaction:
  - State goes to IDLE, counter to 0.
  - All outputs go to 0, including mem_req, mem_we, mem_addr, mem_wdata, mem_funct3, dm_rdata, if_rdata, dm_done, if_valid and bus_err.
  - The outstanding memory transaction is abandoned, and any late ack is ignored.

## Timing
- Grant is decided at the edge ending an IDLE cycle. mem_req is high from the next cycle.
- ack sampled high at edge N → done/valid and rdata are high during cycle N+1, and the state is IDLE in that same cycle.
- Minimum access is 3 cycles: request, mem_req+ack, done.
- Back-to-back: in the done cycle of a data access, a pending eligible fetch is granted at that cycle's end. There are no extra bubbles.
- The done/valid pulse is exactly one cycle.
- mem_req never drops without ack or timeout.
- At most one transaction is outstanding.

## Test plan
- Single fetch, ack on first mem_req cycle:
  - Stimulus: if_req=1, if_addr=0x40, mem_rdata=0x00500093.
  - Required: mem_req in cycle 1, if_valid with if_rdata=0x00500093 in cycle 2, stall_if high in cycles 0–1 and low in cycle 2.
- Simultaneous lw and fetch:
  - Stimulus: dm_read=1, dm_addr=0x100, if_req=1, ack after 2 wait cycles.
  - Required: DATA granted first, with mem_we=0 and mem_addr=0x100. dm_done pulses, FETCH is granted at the end of the done cycle, and mem_addr=if_addr.
- sw:
  - Stimulus: dm_write=1, dm_wdata=0xDEADBEEF, dm_funct3=3'b010.
  - Required: mem_we=1, mem_wdata=0xDEADBEEF, dm_rdata=0 on dm_done, and stall_mem drops in the done cycle.
- Input change after grant:
  - Stimulus: change dm_addr while mem_req is high.
  - Required: mem_addr stays at the latched value until ack.
- Timeout with TIMEOUT=4 and mem_ack held at 0:
  - Required: mem_req high for exactly 4 cycles, then dm_done with dm_rdata=0, and bus_err=1 and sticky until reset.
- Reset asserted mid-FETCH, then ack arrives after reset release:
  - Required: all outputs 0 immediately after reset, the late ack is ignored, and no if_valid pulse occurs.
